// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: control-unit load/store cases,
// FSM states, byte-enable patterns and the alignment rule.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    LdLw  = 3'b000,
    LdLh  = 3'b001,
    LdLhu = 3'b010,
    LdLb  = 3'b011,
    LdLbu = 3'b100
  } load_case_e;

  typedef enum logic [1:0] {
    WrSw = 2'b00,
    WrSh = 2'b01,
    WrSb = 2'b10
  } write_case_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [3:0] BeWord   = 4'b1111;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeByte0  = 4'b0001;

  // Undefined encodings fall back to word accesses and so need word alignment.
  function automatic logic access_aligned(input logic       we,
                                          input logic [2:0] lc,
                                          input logic [1:0] wc,
                                          input logic [1:0] off);
    logic ok;
    ok = (off == 2'b00);
    if (we) begin
      if (wc == WrSh) ok = ~off[0];
      else if (wc == WrSb) ok = 1'b1;
    end else begin
      if (lc == LdLh || lc == LdLhu) ok = ~off[0];
      else if (lc == LdLb || lc == LdLbu) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data formatter: selects the addressed byte/half lane and sign- or zero-extends it.
// Purely combinational; shared by the integer and FPU load paths.
module mem_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  load_case,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (load_case)
      LdLh:    data = {{16{half_sel[15]}}, half_sel};
      LdLhu:   data = {16'h0000, half_sel};
      LdLb:    data = {{24{byte_sel[7]}}, byte_sel};
      LdLbu:   data = {24'h000000, byte_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: converts level-held control requests into one req/ack bus
// transaction with a busy stall. Optional bus watchdog enabled by MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic [2:0]        iLoadCase,
  input  logic [1:0]        iWriteCase,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWData,
  output logic              oBusy,
  output logic              oDone,
  output logic [31:0]       oRData,
  output logic              oMisaligned,
  output logic              oBusErr,
  output logic              oBusReq,
  output logic              oBusWe,
  output logic [ADDR_W-1:0] oBusAddr,
  output logic [3:0]        oBusByteEn,
  output logic [31:0]       oBusWData,
  input  logic              iBusAck,
  input  logic [31:0]       iBusRData
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [2:0]        load_case_q;
  logic [1:0]        write_case_q;
  logic              we_q, misalign_q, bus_err_q;
  logic              req, aligned, accept, misalign_d, timeout, bus_req;
  logic [31:0]       load_data, wdata_rep;
  logic [3:0]        byte_en;

  assign req     = iMemRead | iMemWrite;
  assign aligned = access_aligned(iMemWrite, iLoadCase, iWriteCase, iAddr[1:0]);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Held at zero outside BUS so every bus access starts a fresh count.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) wait_cnt_q <= '0;
    else if (state_q != StBus) wait_cnt_q <= '0;
    else if (!iBusAck) wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  assign timeout = (state_q == StBus) && !iBusAck && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (aligned) begin
            accept  = 1'b1;
            state_d = StBus;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      StBus: begin
        if (iBusAck) state_d = StDone;
        else if (timeout) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      load_case_q  <= '0;
      write_case_q <= '0;
      we_q         <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
      bus_err_q  <= timeout;
      if (accept) begin
        addr_q       <= iAddr;
        wdata_q      <= iWData;
        load_case_q  <= iLoadCase;
        write_case_q <= iWriteCase;
        we_q         <= iMemWrite;
      end
      if (state_q == StBus && iBusAck && !we_q) rdata_q <= load_data;
    end
  end

  mem_load_align u_load_align (
    .rdata    (iBusRData),
    .byte_off (addr_q[1:0]),
    .load_case(load_case_q),
    .data     (load_data)
  );

  always_comb begin
    byte_en   = BeWord;
    wdata_rep = wdata_q;
    if (we_q) begin
      case (write_case_q)
        WrSh: begin
          byte_en   = addr_q[1] ? BeHalfHi : BeHalfLo;
          wdata_rep = {2{wdata_q[15:0]}};
        end
        WrSb: begin
          byte_en   = BeByte0 << addr_q[1:0];
          wdata_rep = {4{wdata_q[7:0]}};
        end
        default: ;
      endcase
    end
  end

  assign bus_req     = (state_q == StBus);
  assign oBusReq     = bus_req;
  assign oBusWe      = bus_req & we_q;
  assign oBusAddr    = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign oBusByteEn  = bus_req ? byte_en : 4'b0000;
  assign oBusWData   = bus_req ? wdata_rep : 32'h0;
  assign oBusy       = bus_req | ((state_q == StIdle) & req & aligned);
  assign oDone       = (state_q == StDone);
  assign oRData      = rdata_q;
  assign oMisaligned = misalign_q;
  assign oBusErr     = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the timeout scenario follows MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  load_case = '0;
  logic [1:0]  write_case = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .iCLK(clk), .iRST(rst), .iMemRead(mem_read), .iMemWrite(mem_write),
    .iLoadCase(load_case), .iWriteCase(write_case), .iAddr(addr), .iWData(wdata),
    .oBusy(busy), .oDone(done), .oRData(rdata), .oMisaligned(misaligned),
    .oBusErr(bus_err), .oBusReq(bus_req), .oBusWe(bus_we), .oBusAddr(bus_addr),
    .oBusByteEn(bus_be), .oBusWData(bus_wdata), .iBusAck(bus_ack), .iBusRData(bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] lc,
                       input logic [1:0] wc, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; load_case = lc; write_case = wc; addr = a; wdata = wd;
    #1;
  endtask

  // Leaves the DUT in its DONE cycle with the request still held, as control would.
  task automatic run_read(input logic [2:0] lc, input logic [31:0] a, input logic [31:0] rd);
    drive(1'b1, 1'b0, lc, 2'b00, a, 32'h0);
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    tick();
  endtask

  task automatic finish_access();
    tick();
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if ({busy, done, rdata, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata}
        !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, rdata=%h addr=%h be=%b",
                         rdata, bus_addr, bus_be);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0104, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    checks++;
    if (busy !== 1'b1 || bus_req !== 1'b0) begin
      errors++; $display("FAIL lw_idle: busy=%b req=%b want 1,0", busy, bus_req);
    end
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b1111) begin
      errors++; $display("FAIL lw_bus: req=%b we=%b be=%b want 1,0,1111", bus_req, bus_we, bus_be);
    end
    checks++;
    if (bus_addr !== 32'h0000_0104) begin
      errors++; $display("FAIL lw_addr: got %h want 00000104", bus_addr);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL lw_bus_busy: done=%b busy=%b want 0,1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL lw_done: done=%b busy=%b req=%b want 1,0,0", done, busy, bus_req);
    end
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_rdata: got %h want deadbeef", rdata);
    end
    finish_access();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL lw_after: done=%b busy=%b want 0,0", done, busy);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  lcs [7] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b011, 3'b001, 3'b111};
    logic [31:0] as  [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h100};
    logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_8011,
                             32'h0000_0033, 32'h0000_2233, 32'h8011_2233};
    for (int i = 0; i < 7; i++) begin
      run_read(lcs[i], as[i], 32'h8011_2233);
      checks++;
      if (done !== 1'b1 || rdata !== exp[i]) begin
        errors++; $display("FAIL load_ext[%0d]: done=%b rdata=%h want 1,%h", i, done, rdata, exp[i]);
      end
      finish_access();
    end
  endtask

  task automatic test_store();
    logic        rds [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  wcs [5] = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
    logic [31:0] as  [5] = '{32'h202, 32'h202, 32'h200, 32'h204, 32'h201};
    logic [31:0] wds [5] = '{32'hA5, 32'h1234, 32'hBEEF, 32'hCAFE_F00D, 32'h1122_335C};
    logic [3:0]  ebe [5] = '{4'b0100, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [31:0] ewd [5] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'hBEEF_BEEF, 32'hCAFE_F00D,
                             32'h5C5C_5C5C};
    logic [31:0] eaddr [5] = '{32'h200, 32'h200, 32'h200, 32'h204, 32'h200};
    for (int i = 0; i < 5; i++) begin
      drive(rds[i], 1'b1, 3'b000, wcs[i], as[i], wds[i]);
      bus_ack = 1'b1; bus_rdata = 32'h0F0F_0F0F;
      tick();
      checks++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== ebe[i]) begin
        errors++; $display("FAIL store_ctl[%0d]: req=%b we=%b be=%b want 1,1,%b",
                           i, bus_req, bus_we, bus_be, ebe[i]);
      end
      checks++;
      if (bus_wdata !== ewd[i] || bus_addr !== eaddr[i]) begin
        errors++; $display("FAIL store_data[%0d]: wdata=%h addr=%h want %h,%h",
                           i, bus_wdata, bus_addr, ewd[i], eaddr[i]);
      end
      tick();
      checks++;
      if (done !== 1'b1 || rdata !== 32'h8011_2233) begin
        errors++; $display("FAIL store_done[%0d]: done=%b rdata=%h want 1,80112233",
                           i, done, rdata);
      end
      finish_access();
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 3'b001, 2'b00, 32'h101, 32'h0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mis_busy: got %b want 0", busy);
    end
    tick();
    checks++;
    if (misaligned !== 1'b1 || bus_req !== 1'b0) begin
      errors++; $display("FAIL mis_pulse: mis=%b req=%b want 1,0", misaligned, bus_req);
    end
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h108, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mis_next_busy: got %b want 1", busy);
    end
    tick();
    checks++;
    if (misaligned !== 1'b0 || bus_req !== 1'b1 || bus_addr !== 32'h108) begin
      errors++; $display("FAIL mis_next_bus: mis=%b req=%b addr=%h want 0,1,108",
                         misaligned, bus_req, bus_addr);
    end
    tick();
    checks++;
    if (done !== 1'b1 || rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mis_next_done: done=%b rdata=%h want 1,0badf00d", done, rdata);
    end
    finish_access();
    drive(1'b0, 1'b1, 3'b000, 2'b00, 32'h102, 32'h55);
    tick();
    checks++;
    if (misaligned !== 1'b1 || bus_req !== 1'b0) begin
      errors++; $display("FAIL mis_sw: mis=%b req=%b want 1,0", misaligned, bus_req);
    end
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if (misaligned !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mis_clear: mis=%b req=%b done=%b want 0,0,0",
                         misaligned, bus_req, done);
    end
  endtask

  task automatic test_back_to_back();
    run_read(3'b000, 32'h600, 32'h1357_9BDF);
    tick();
    drive(1'b1, 1'b0, 3'b011, 2'b00, 32'h601, 32'h0);
    bus_rdata = 32'h0000_AB00;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || rdata !== 32'h1357_9BDF) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b rdata=%h want 1,0,13579bdf",
                         busy, done, rdata);
    end
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h600) begin
      errors++; $display("FAIL b2b_bus: req=%b addr=%h want 1,600", bus_req, bus_addr);
    end
    tick();
    checks++;
    if (done !== 1'b1 || rdata !== 32'hFFFF_FFAB) begin
      errors++; $display("FAIL b2b_done: done=%b rdata=%h want 1,ffffffab", done, rdata);
    end
    finish_access();
  endtask

  task automatic test_wait_and_reset();
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h300, 32'h0);
    bus_ack = 1'b0; bus_rdata = 32'h1122_3344;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || bus_addr !== 32'h300) begin
        errors++; $display("FAIL wait[%0d]: req=%b busy=%b done=%b addr=%h want 1,1,0,300",
                           i, bus_req, busy, done, bus_addr);
      end
      tick();
    end
    bus_ack = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || rdata !== 32'h1122_3344) begin
      errors++; $display("FAIL wait_done: done=%b rdata=%h want 1,11223344", done, rdata);
    end
    finish_access();
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h400, 32'h0);
    tick();
    tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL rst_pre: req=%b want 1", bus_req);
    end
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid: req=%b done=%b busy=%b rdata=%h want 0,0,0,0",
                         bus_req, done, busy, rdata);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || bus_req !== 1'b0) begin
        errors++; $display("FAIL rst_after[%0d]: done=%b req=%b want 0,0", i, done, bus_req);
      end
    end
  endtask

  task automatic test_timeout();
    run_read(3'b000, 32'h700, 32'h5A5A_0001);
    finish_access();
    drive(1'b1, 1'b0, 3'b000, 2'b00, 32'h704, 32'h0);
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus_req !== 1'b1 || bus_err !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL to_wait[%0d]: req=%b err=%b done=%b want 1,0,0",
                           i, bus_req, bus_err, done);
      end
      tick();
    end
    checks++;
    if (bus_err !== 1'b1 || bus_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL to_err: err=%b req=%b done=%b want 1,0,0", bus_err, bus_req, done);
    end
    checks++;
    if (rdata !== 32'h5A5A_0001) begin
      errors++; $display("FAIL to_rdata: got %h want 5a5a0001", rdata);
    end
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL to_busy: got %b want 0", busy);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL to_clear: err=%b done=%b want 0,0", bus_err, done);
    end
`else
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (busy !== 1'b1 || bus_req !== 1'b1 || done !== 1'b0 || bus_err !== 1'b0) begin
        errors++; $display("FAIL no_to[%0d]: busy=%b req=%b done=%b err=%b want 1,1,0,0",
                           i, busy, bus_req, done, bus_err);
      end
      tick();
    end
    checks++;
    if (rdata !== 32'h5A5A_0001) begin
      errors++; $display("FAIL no_to_rdata: got %h want 5a5a0001", rdata);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_wait_and_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
